// File: rtl/machine_d_driver.sv
// machine_d_driver
//   Serial stimulus initiator for the 3-bit D-flip-flop state machine
//   (input x, state S[2:0], output F). It shifts a programmable pattern onto
//   x, LSB first, one bit per clock. A lock-step model of the machine's
//   next-state logic runs alongside and is compared with the machine's
//   observed S/F. Any divergence sets a sticky flag.
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous, active-high reset (overrides start)
//   start     in   burst request, honoured only in IDLE
//   pattern   in   [MAX_LEN-1:0] bits to send, bit 0 first
//   len       in   [LEN_W-1:0] bit count, clamped to MAX_LEN; 0 = empty burst
//   check_en  in   enables the S/F comparison
//   S_obs     in   [2:0] machine state observed from the target
//   F_obs     in   machine output F observed from the target
//   x         out  registered serial bit to the machine
//   busy      out  high while a burst is in progress
//   done      out  one-cycle pulse after the last bit
//   exp_S     out  [2:0] model state, registered
//   hit       out  model F, decoded from exp_S
//   mismatch  out  sticky divergence flag
//
// state | meaning
// IDLE  | no burst; x = IDLE_X; a start with len != 0 launches SEND
// SEND  | shifting pattern onto x; cnt = bits still to send after current one
module machine_d_driver #(
  parameter int   MAX_LEN = 8,
  parameter int   LEN_W   = 4,
  parameter logic IDLE_X  = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               check_en,
  input  logic [2:0]         S_obs,
  input  logic               F_obs,
  output logic               x,
  output logic               busy,
  output logic               done,
  output logic [2:0]         exp_S,
  output logic               hit,
  output logic               mismatch
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] shreg;
  logic [LEN_W-1:0]   cnt;

  logic [LEN_W-1:0] len_eff;
  logic             accept;
  logic             cmp_fail;
  logic [2:0]       exp_next;

  assign len_eff = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign accept  = (state == IDLE) && start;

  // Model of the machine's next-state logic, driven by the same registered x
  // the machine sees, so exp_S stays cycle-aligned with S_obs.
  assign exp_next[2] = exp_S[2] | (~x & exp_S[1]);
  assign exp_next[1] = (exp_S[1] & exp_S[2]) | ~(exp_S[1] ^ x);
  assign exp_next[0] = exp_S[0] ^ x;

  assign hit      = exp_S[2] & exp_S[1] & ~exp_S[0];
  assign cmp_fail = check_en && ((S_obs != exp_S) || (F_obs != hit));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      x        <= IDLE_X;
      busy     <= 1'b0;
      done     <= 1'b0;
      exp_S    <= 3'b000;
      mismatch <= 1'b0;
    end else begin
      exp_S <= exp_next;
      done  <= 1'b0;

      // A divergence seen on the same edge as a new start must not be lost.
      if (cmp_fail) begin
        mismatch <= 1'b1;
      end else if (accept) begin
        mismatch <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state <= SEND;
              shreg <= pattern >> 1;
              cnt   <= len_eff - LEN_W'(1);
              x     <= pattern[0];
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (cnt != '0) begin
            x     <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= cnt - LEN_W'(1);
          end else begin
            x     <= IDLE_X;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
